// File: rtl/filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// filter_frame_ctrl
//
// Frame-level sequencer for the masked 2D filter. A start command latches the
// frame configuration (height, width, kernel size), which is validated for one
// cycle. A valid frame releases the address generator from reset and every
// output-pixel write it issues is counted and checked against raster order.
// After the last write the sequencer waits for the datapath pipeline to drain,
// then pulses done. Invalid configurations park the block in an error state.
//
// Ports
//   clk        system clock, all state on posedge
//   rst        asynchronous, active-low reset
//   start      frame start request (single-cycle or held)
//   abort      cancel the current frame
//   h_in/w_in  frame height / width in pixels
//   n_in       kernel size (must be odd, <= MAX_N)
//   wr_en      write strobe from the address generator
//   wr_addr    write address from the address generator
//   h/w/n      latched configuration, stable for the whole frame
//   gen_rst    active-low reset to the address generator (low = held)
//   busy       frame in progress (LOAD/RUN/DRAIN)
//   done       one-cycle pulse, frame completed
//   err        configuration error, sticky until the next accepted start
//   seq_err    write address sequence error, sticky until next accepted start
//   pix_count  writes counted in the current frame
// -----------------------------------------------------------------------------
module filter_frame_ctrl #(
   parameter int WORD  = 16,
   parameter int MAX_N = 25,
   parameter int DRAIN = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD-1:0]   h_in,
   input  logic [WORD-1:0]   w_in,
   input  logic [WORD-1:0]   n_in,
   input  logic              wr_en,
   input  logic [WORD:0]     wr_addr,
   output logic [WORD-1:0]   h,
   output logic [WORD-1:0]   w,
   output logic [WORD-1:0]   n,
   output logic              gen_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              seq_err,
   output logic [2*WORD-1:0] pix_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_ERR
   } state_e;

   localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   // Largest frame the WORD+1 bit address bus can cover.
   localparam logic [2*WORD-1:0] ADDR_SPACE = (2*WORD)'(1) << (WORD + 1);

   state_e              state_q, state_d;
   logic [WORD-1:0]     h_q, h_d;
   logic [WORD-1:0]     w_q, w_d;
   logic [WORD-1:0]     n_q, n_d;
   logic [2*WORD-1:0]   total_q, total_d;
   logic [2*WORD-1:0]   pix_q, pix_d;
   logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
   logic                gen_rst_q, gen_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                seq_err_q, seq_err_d;

   logic [2*WORD-1:0]   area;
   logic                cfg_ok;

   assign area   = (2*WORD)'(h_q) * (2*WORD)'(w_q);
   assign cfg_ok = (h_q != '0) && (w_q != '0) && n_q[0] &&
                   (n_q <= WORD'(MAX_N)) && (area <= ADDR_SPACE);

   // NOTE: every signal assigned here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      w_d         = w_q;
      n_d         = n_q;
      total_d     = total_q;
      pix_d       = pix_q;
      drain_cnt_d = drain_cnt_q;
      err_d       = err_q;
      seq_err_d   = seq_err_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE, S_ERR: begin
            // start outranks abort here; abort has no meaning outside a frame.
            if (start) begin
               h_d       = h_in;
               w_d       = w_in;
               n_d       = n_in;
               err_d     = 1'b0;
               seq_err_d = 1'b0;
               pix_d     = '0;
               state_d   = S_LOAD;
            end
         end

         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cfg_ok) begin
               total_d = area;
               state_d = S_RUN;
            end else begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end

         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (wr_en) begin
               // Expected address is simply the running write count.
               if (wr_addr != pix_q[WORD:0]) begin
                  seq_err_d = 1'b1;
               end
               if (pix_q < total_q) begin
                  pix_d = pix_q + 1'b1;
               end
               if (pix_q == total_q - 1'b1) begin
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               // Writes after the last pixel are illegal and not counted.
               if (wr_en) begin
                  seq_err_d = 1'b1;
               end
               if (drain_cnt_q == DCW'(DRAIN - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  drain_cnt_d = drain_cnt_q + 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      gen_rst_d = (state_d == S_RUN);
      busy_d    = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before this edge regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         w_q         <= '0;
         n_q         <= '0;
         total_q     <= '0;
         pix_q       <= '0;
         drain_cnt_q <= '0;
         gen_rst_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         w_q         <= w_d;
         n_q         <= n_d;
         total_q     <= total_d;
         pix_q       <= pix_d;
         drain_cnt_q <= drain_cnt_d;
         gen_rst_q   <= gen_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         seq_err_q   <= seq_err_d;
      end
   end

   assign h         = h_q;
   assign w         = w_q;
   assign n         = n_q;
   assign gen_rst   = gen_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign seq_err   = seq_err_q;
   assign pix_count = pix_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_frame_ctrl
//
// Frame-level bench for filter_frame_ctrl. A behavioural address generator
// issues writes on the negedge; the expected end-of-frame event (done, config
// error, or stop by abort/reset) is pushed into a scoreboard queue when the
// stimulus creates it, and an independent monitor pops and compares whenever
// the DUT signals a frame end.
// -----------------------------------------------------------------------------
module tb_filter_frame_ctrl;

   localparam int WORD  = 16;
   localparam int MAX_N = 25;
   localparam int DRAIN = 3;

   typedef enum int {EV_DONE, EV_ERR, EV_STOP} ev_kind_e;

   typedef struct {
      ev_kind_e kind;
      longint   cyc;
      longint   pix;
      bit       seq;
      int       hh;
      int       ww;
      int       nn;
   } ev_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic              abort;
   logic [WORD-1:0]   h_in;
   logic [WORD-1:0]   w_in;
   logic [WORD-1:0]   n_in;
   logic              wr_en;
   logic [WORD:0]     wr_addr;
   logic [WORD-1:0]   h;
   logic [WORD-1:0]   w;
   logic [WORD-1:0]   n;
   logic              gen_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic              seq_err;
   logic [2*WORD-1:0] pix_count;

   filter_frame_ctrl #(.WORD(WORD), .MAX_N(MAX_N), .DRAIN(DRAIN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .h_in     (h_in),
      .w_in     (w_in),
      .n_in     (n_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .h        (h),
      .w        (w),
      .n        (n),
      .gen_rst  (gen_rst),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .seq_err  (seq_err),
      .pix_count(pix_count)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc      = 0;
   ev_t    sb_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count of posedges seen; stable when read at a negedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input ev_kind_e k, input longint c, input longint p,
                          input bit s, input int hh, input int ww, input int nn);
      ev_t e;
      e.kind = k; e.cyc = c; e.pix = p; e.seq = s;
      e.hh = hh; e.ww = ww; e.nn = nn;
      sb_q.push_back(e);
   endtask

   // ---------------------------------------------------------------- monitor
   bit       busy_prev = 1'b0;
   bit       err_prev  = 1'b0;
   ev_t      mon_e;
   ev_kind_e kind_obs;
   bit       seen;

   always @(negedge clk) begin
      seen = 1'b1;
      if (done === 1'b1)                                  kind_obs = EV_DONE;
      else if (err === 1'b1 && !err_prev)                 kind_obs = EV_ERR;
      else if (busy_prev && busy === 1'b0 && err !== 1'b1) kind_obs = EV_STOP;
      else                                                seen = 1'b0;

      if (seen) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d with nothing expected (cycle %0d)",
                     int'(kind_obs), cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("ev_kind",    int'(kind_obs), int'(mon_e.kind));
            check("ev_cycle",   cyc,            mon_e.cyc);
            check("ev_busy",    busy,           0);
            check("ev_gen_rst", gen_rst,        0);
            check("ev_h",       h,              mon_e.hh);
            check("ev_w",       w,              mon_e.ww);
            check("ev_n",       n,              mon_e.nn);
            if (mon_e.kind == EV_ERR) begin
               check("ev_pix", pix_count, 0);
            end else begin
               check("ev_pix",     pix_count, mon_e.pix);
               check("ev_seq_err", seq_err,   mon_e.seq);
               check("ev_err",     err,       0);
            end
         end
      end
      busy_prev = (busy === 1'b1);
      err_prev  = (err === 1'b1);
   end

   // ---------------------------------------------------- behavioural frame
   // skip_at: first write index whose address is bumped by one (-1 = none)
   // abort_after / rst_after: stop after that many writes (-1 = never)
   // start_at: write index during which start is pulsed again (-1 = never)
   task automatic run_frame(input int hh, input int ww, input int nn,
                            input int skip_at, input int abort_after,
                            input int start_at, input int rst_after,
                            input bit drain_wr, input int gap_pct);
      longint t, l, total;
      bit     valid, seq;
      int     k, addr;

      @(negedge clk);
      start = 1'b1;
      abort = 1'($urandom_range(0, 1));   // start must win over abort here
      h_in  = 16'(hh);
      w_in  = 16'(ww);
      n_in  = 16'(nn);
      t     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      h_in  = 16'($urandom);
      w_in  = 16'($urandom);
      n_in  = 16'($urandom);
      check("load_busy",   busy, 1);
      check("load_err",    err,  0);
      check("load_h",      h,    hh);
      check("load_pix",    pix_count, 0);

      total = longint'(hh) * longint'(ww);
      valid = (hh != 0) && (ww != 0) && (nn % 2 == 1) && (nn <= MAX_N) &&
              (total <= (longint'(1) << (WORD + 1)));

      if (!valid) begin
         push_ev(EV_ERR, t + 1, 0, 1'b0, hh, ww, nn);
         repeat (4) begin
            @(negedge clk);
            check("inv_gen_rst", gen_rst, 0);
         end
         check("inv_err", err, 1);
         return;
      end

      @(negedge clk);
      check("run_gen_rst", gen_rst, 1);

      k   = 0;
      seq = 1'b0;
      l   = 0;
      while (longint'(k) < total) begin
         if (k == abort_after) begin
            wr_en = 1'b0;
            abort = 1'b1;
            push_ev(EV_STOP, cyc + 1, k, seq, hh, ww, nn);
            @(negedge clk);
            abort = 1'b0;
            check("abort_pix", pix_count, k);
            repeat (DRAIN + 3) @(negedge clk);
            return;
         end
         if (k == rst_after) begin
            wr_en = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            push_ev(EV_STOP, cyc, 0, 1'b0, 0, 0, 0);
            #1;
            check("arst_busy",    busy,      0);
            check("arst_pix",     pix_count, 0);
            check("arst_h",       h,         0);
            check("arst_gen_rst", gen_rst,   0);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         if ($urandom_range(0, 99) < gap_pct) begin
            wr_en = 1'b0;
            @(negedge clk);
            continue;
         end
         addr = (skip_at >= 0 && k >= skip_at) ? k + 1 : k;
         if (addr != k) seq = 1'b1;
         wr_en   = 1'b1;
         wr_addr = 17'(addr);
         if (k == start_at) begin
            start = 1'b1;
            h_in  = 16'(hh + 3);
            w_in  = 16'(ww + 1);
            n_in  = 16'(nn + 2);
         end
         l = cyc + 1;
         @(negedge clk);
         wr_en = 1'b0;
         start = 1'b0;
         if (k == skip_at) check("seq_err_at_fault", seq_err, 1);
         k++;
      end

      // Last write was sampled at edge l; now observing the cycle after it.
      seq = seq | drain_wr;
      push_ev(EV_DONE, l + DRAIN, total, seq, hh, ww, nn);
      check("drain_gen_rst", gen_rst,   0);
      check("drain_busy",    busy,      1);
      check("drain_pix",     pix_count, total);
      if (drain_wr) begin
         wr_en   = 1'b1;
         wr_addr = 17'(total);
         @(negedge clk);
         wr_en = 1'b0;
         check("drain_wr_pix", pix_count, total);
         check("drain_wr_seq", seq_err,   1);
      end
      repeat (DRAIN + 3) @(negedge clk);
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int hh, ww, nn, sel, skip;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      h_in = '0; w_in = '0; n_in = '0; wr_en = 1'b0; wr_addr = '0;
      #1;
      check("rst_busy",    busy,      0);
      check("rst_gen_rst", gen_rst,   0);
      check("rst_done",    done,      0);
      check("rst_err",     err,       0);
      check("rst_seq_err", seq_err,   0);
      check("rst_pix",     pix_count, 0);
      check("rst_hwn",     {h, w, n}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // normal frame, no gaps
      run_frame(4, 4, 3, -1, -1, -1, -1, 1'b0, 0);
      // invalid configurations, then a valid start clears err
      run_frame(4, 4, 4, -1, -1, -1, -1, 1'b0, 0);
      run_frame(0, 4, 3, -1, -1, -1, -1, 1'b0, 0);
      run_frame(4, 4, 27, -1, -1, -1, -1, 1'b0, 0);
      run_frame(4, 4, 3, -1, -1, -1, -1, 1'b0, 20);
      // address fault: 0,1,3,4,5,6
      run_frame(2, 3, 3, 2, -1, -1, -1, 1'b0, 0);
      // abort after 10 writes
      run_frame(8, 8, 3, -1, 10, -1, -1, 1'b0, 0);
      // start while busy is ignored
      run_frame(4, 4, 3, -1, -1, 5, -1, 1'b0, 0);
      // async reset mid-run, then a full frame
      run_frame(4, 4, 3, -1, -1, -1, 7, 1'b0, 0);
      run_frame(4, 4, 3, -1, -1, -1, -1, 1'b0, 10);
      // boundaries: full address space valid, one column more invalid,
      // largest kernel, 1x1 frame, write during drain
      run_frame(256, 512, 25, -1, 3, -1, -1, 1'b0, 0);
      run_frame(256, 513, 3, -1, -1, -1, -1, 1'b0, 0);
      run_frame(1, 1, 1, -1, -1, -1, -1, 1'b0, 0);
      run_frame(3, 2, 25, -1, -1, -1, -1, 1'b1, 0);

      for (int r = 0; r < 25; r++) begin
         hh  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         ww  = $urandom_range(1, 6);
         sel = $urandom_range(0, 5);
         if (sel == 0)      nn = 2 * $urandom_range(0, 12);
         else if (sel == 1) nn = 27;
         else               nn = 2 * $urandom_range(0, 12) + 1;
         skip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, hh * ww) : -1;
         run_frame(hh, ww, nn, skip, -1, -1, -1,
                   1'($urandom_range(0, 4) == 0), 30);
      end

      repeat (DRAIN + 2) @(negedge clk);
      check("events_pending", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/filter_frame_ctrl.md
# filter_frame_ctrl

Frame-level sequencer for the masked 2D filter. It latches a frame configuration (height, width, kernel size) on a start command and validates it. It then releases the address generator from reset and counts the output-pixel writes it issues, checking each write address against the expected raster order. After the last write it waits for the datapath pipeline to drain, then reports completion or error to the host/top level.

## Interface
- WORD, 16, width of h/w/n configuration words
- MAX_N, 25, largest legal kernel size (odd)
- DRAIN, 3, cycles waited after last write before `done`
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request, single-cycle or held
- abort  in  1  cancel current frame
- h_in  in  WORD  frame height in pixels
- w_in  in  WORD  frame width in pixels
- n_in  in  WORD  kernel size
- wr_en  in  1  write enable from address generator
- wr_addr  in  WORD+1  write address from address generator
- h  out  WORD  latched height to datapath
- w  out  WORD  latched width to datapath
- n  out  WORD  latched kernel size to datapath
- gen_rst  out  1  active-low reset to address generator; low = held
- busy  out  1  frame in progress (LOAD/RUN/DRAIN)
- done  out  1  one-cycle pulse, frame completed cleanly
- err  out  1  config error, sticky until next accepted start
- seq_err  out  1  address sequence error, sticky until next accepted start
- pix_count  out  2*WORD  writes counted in current frame

## Operation
- States: IDLE, LOAD, RUN, DRAIN, ERR.
- Reset: state IDLE, h=w=n=0, gen_rst=0, busy=0, done=0, err=0, seq_err=0, pix_count=0.
- IDLE/ERR + start: latch h_in/w_in/n_in into h/w/n, clear err, seq_err and pix_count, go to LOAD.
- start in LOAD/RUN/DRAIN is ignored.
- LOAD (1 cycle): validate the config.
  - Invalid if h==0, w==0, n even, n>MAX_N, or h*w > 2^(WORD+1) (address space).
  - Invalid: go to ERR, err=1, gen_rst stays 0.
  - Valid: go to RUN, compute total=h*w in 2*WORD bits.
- RUN: gen_rst=1.
  - Each posedge with wr_en=1: if wr_addr != pix_count[WORD:0], set seq_err=1. Then pix_count++.
  - On the write where pix_count==total-1: go to DRAIN, gen_rst=0 from the next cycle.
  - seq_err does not stop the frame.
- DRAIN: count DRAIN cycles, then go to IDLE and pulse done for one cycle.
  - wr_en asserted in DRAIN is ignored by the counter and sets seq_err.
- ERR: gen_rst=0, err=1. Stays here until the next start.
- abort in LOAD/RUN/DRAIN: go to IDLE next cycle, gen_rst=0, no done.
  - pix_count holds its value for inspection.
- abort in IDLE/ERR has no effect. If abort and start are both high in IDLE, start wins.
- Arithmetic: all counts unsigned. pix_count saturates at total and never wraps.

## Timing
- start sampled at cycle T: LOAD at T+1; RUN (gen_rst=1) at T+2 for a valid config; ERR/err=1 at T+2 for an invalid one.
- wr_en is driven on the generator's negedge and sampled here on posedge. It therefore appears here half a cycle after the generator drives it.
- Last write sampled at cycle L: gen_rst=0 and busy=1 at L+1; done=1 at L+1+DRAIN for one cycle, with busy=0 in the same cycle.
- busy is registered and equals state ∈ {LOAD, RUN, DRAIN}.
- Outputs h/w/n change only on an accepted start and are stable for the whole frame.
- Asynchronous reset mid-frame: all outputs return to reset values immediately; no done.

## Test plan
- Normal frame: h=4, w=4, n=3, behavioural generator issuing writes 0..15. Expect done exactly DRAIN=3 cycles after the write of 15 is sampled, pix_count=16, err=0, seq_err=0.
- Invalid config: n=4, then separately h=0 and n=27. Expect err=1 two cycles after start, gen_rst never 1, no done; a subsequent valid start clears err.
- Address fault: h=2, w=3, n=3, generator skips address 2 (writes 0,1,3,4,5,6). Expect seq_err=1 at the write of 3, done still asserted after 6 writes.
- Abort: h=8, w=8, abort after 10 writes. Expect busy=0 and gen_rst=0 next cycle, no done pulse, pix_count=10.
- Start while busy: pulse start at write 5 of a 4x4 frame. Expect it ignored, h/w/n unchanged, single done at end.
- Reset mid-RUN: drop rst after 7 writes. Expect all outputs at reset values immediately; new start then runs a full frame correctly.
